// File: rtl/demux_1x4_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x4_reg
// Description : Registered 1-to-4 demultiplexer with a valid/ready handshake.
//               A single producer stream is steered by {s1,s0} into one of
//               four single-word lane holding registers. Each lane keeps a
//               wrapping count of the words its consumer has taken.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x4_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s1,
    input  logic             s0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             vld_a,
    output logic             vld_b,
    output logic             vld_c,
    output logic             vld_d,
    input  logic             rdy_a,
    input  logic             rdy_b,
    input  logic             rdy_c,
    input  logic             rdy_d,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    localparam int c_LANES = 4;

    logic [1:0]         w_sel;
    logic [3:0]         w_rdy;
    logic [3:0]         w_vld;
    logic               w_acc;
    logic [WIDTH-1:0]   w_data [c_LANES];
    logic [CNT_W-1:0]   w_cnt  [c_LANES];

    assign w_sel = {s1, s0};
    assign w_rdy = {rdy_d, rdy_c, rdy_b, rdy_a};

    // Backpressure comes straight from the selected lane: a lane can take a
    // new word when it is empty or its current word leaves on this edge.
    assign in_ready = !w_vld[w_sel] || w_rdy[w_sel];
    assign w_acc    = in_valid && in_ready;

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            logic [WIDTH-1:0] r_data;
            logic             r_vld;
            logic [CNT_W-1:0] r_cnt;
            logic             w_load;
            logic             w_drain;

            assign w_load  = w_acc && (w_sel == 2'(i));
            assign w_drain = r_vld && w_rdy[i];

            // Lane holding register: a load wins over a drain so a word can
            // enter and leave in the same cycle; a drain alone only clears
            // the flag and leaves the stale data visible.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_data <= '0;
                    r_vld  <= 1'b0;
                end else if (w_load) begin
                    r_data <= in_data;
                    r_vld  <= 1'b1;
                end else if (w_drain) begin
                    r_vld  <= 1'b0;
                end
            end

            // Completed-transfer counter, wraps naturally at 2^CNT_W.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_drain) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_data[i] = r_data;
            assign w_vld[i]  = r_vld;
            assign w_cnt[i]  = r_cnt;
        end
    endgenerate

    assign out_a = w_data[0];
    assign out_b = w_data[1];
    assign out_c = w_data[2];
    assign out_d = w_data[3];
    assign vld_a = w_vld[0];
    assign vld_b = w_vld[1];
    assign vld_c = w_vld[2];
    assign vld_d = w_vld[3];
    assign cnt_a = w_cnt[0];
    assign cnt_b = w_cnt[1];
    assign cnt_c = w_cnt[2];
    assign cnt_d = w_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x4_reg
// Description : Self-checking bench for demux_1x4_reg. A lane-level model
//               tracks the expected contents; directed sequences exercise
//               the handshake, wrap and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       rdy;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             vld_a, vld_b, vld_c, vld_d;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1x4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .s1(sel[1]), .s0(sel[0]), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .vld_a(vld_a), .vld_b(vld_b), .vld_c(vld_c), .vld_d(vld_d),
        .rdy_a(rdy[0]), .rdy_b(rdy[1]), .rdy_c(rdy[2]), .rdy_d(rdy[3]),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
    );

    always #5 clk = ~clk;

    // DUT outputs gathered per lane for compact comparison
    logic [WIDTH-1:0] d_out [4];
    logic             d_vld [4];
    logic [CNT_W-1:0] d_cnt [4];
    assign d_out[0] = out_a; assign d_out[1] = out_b;
    assign d_out[2] = out_c; assign d_out[3] = out_d;
    assign d_vld[0] = vld_a; assign d_vld[1] = vld_b;
    assign d_vld[2] = vld_c; assign d_vld[3] = vld_d;
    assign d_cnt[0] = cnt_a; assign d_cnt[1] = cnt_b;
    assign d_cnt[2] = cnt_c; assign d_cnt[3] = cnt_d;

    // Lane model: what each lane holds, whether it is still owed to its
    // consumer, and how many words that consumer has taken.
    int unsigned m_word  [4] = '{0, 0, 0, 0};
    bit          m_owed  [4] = '{0, 0, 0, 0};
    int unsigned m_taken [4] = '{0, 0, 0, 0};

    function automatic bit model_ready();
        return !m_owed[sel] || rdy[sel];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                m_word[k] = 0; m_owed[k] = 0; m_taken[k] = 0;
            end
        end else begin
            bit take_in;
            take_in = in_valid && model_ready();
            for (int k = 0; k < 4; k++) begin
                if (m_owed[k] && rdy[k]) begin
                    m_taken[k] = (m_taken[k] + 1) % 256;
                    m_owed[k]  = 0;
                end
            end
            if (take_in) begin
                m_word[sel] = in_data;
                m_owed[sel] = 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare DUT against the model away from the rising edge
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check($sformatf("model_vld[%0d]", k), 64'(d_vld[k]), 64'(m_owed[k]));
            check($sformatf("model_out[%0d]", k), 64'(d_out[k]), 64'(m_word[k]));
            check($sformatf("model_cnt[%0d]", k), 64'(d_cnt[k]), 64'(m_taken[k]));
        end
        check("model_in_ready", 64'(in_ready), 64'(model_ready()));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        sel      = 2'd0;
        in_valid = 1'b0;
        rdy      = 4'b0000;
        cycle();
        cycle();
        check("reset_vld", 64'({vld_a, vld_b, vld_c, vld_d}), 64'h0);
        check("reset_cnt", 64'({cnt_a, cnt_b, cnt_c, cnt_d}), 64'h0);
        reset_n = 1'b1;

        // Single word into lane c
        in_data = 32'h0000_00A5; sel = 2'd2; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        check("c_vld", 64'(vld_c), 64'h1);
        check("c_out", 64'(out_c), 64'h0000_00A5);
        check("others_vld", 64'({vld_a, vld_b, vld_d}), 64'h0);
        check("c_full_ready", 64'(in_ready), 64'h0);
        rdy[2] = 1'b1;
        cycle();
        rdy[2] = 1'b0;

        // Lane b full-throughput streaming
        in_data = 32'h1111_1111; sel = 2'd1; in_valid = 1'b1;
        cycle();
        rdy[1] = 1'b1; in_data = 32'h2222_2222;
        cycle();
        #1;
        check("b_vld_kept", 64'(vld_b), 64'h1);
        check("b_out_new", 64'(out_b), 64'h2222_2222);
        check("b_cnt1", 64'(cnt_b), 64'h1);
        for (int k = 1; k <= 9; k++) begin
            in_data = 32'h2222_2222 + 32'(k);
            #1;
            check("b_no_bubble", 64'(in_ready), 64'h1);
            cycle();
        end
        check("b_cnt10", 64'(cnt_b), 64'd10);
        check("b_last", 64'(out_b), 64'h2222_222B);
        in_valid = 1'b0;
        cycle();
        rdy[1] = 1'b0;

        // Lane a stalled, then redirect to lane d
        in_data = 32'h4444_4444; sel = 2'd0; in_valid = 1'b1;
        cycle();
        in_data = 32'h3333_3333;
        #1;
        check("a_stall_ready", 64'(in_ready), 64'h0);
        cycle();
        check("a_unchanged", 64'(out_a), 64'h4444_4444);
        sel = 2'd3;
        #1;
        check("d_ready", 64'(in_ready), 64'h1);
        cycle();
        in_valid = 1'b0;
        #1;
        check("d_landed", 64'(out_d), 64'h3333_3333);

        // Lane d counter wrap: 256 drains
        in_valid = 1'b1; rdy[3] = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            in_data = 32'hD000_0000 + 32'(k);
            cycle();
            if (k == 255) check("d_cnt255", 64'(cnt_d), 64'd255);
            if (k == 256) check("d_cnt_wrap", 64'(cnt_d), 64'd0);
        end
        check("a_cnt_still0", 64'(cnt_a), 64'd0);
        in_valid = 1'b0; rdy[3] = 1'b0;
        cycle();

        // Ready on an empty lane is ignored
        rdy[0] = 1'b1;
        cycle();
        check("a_drained_cnt", 64'(cnt_a), 64'd1);
        for (int k = 0; k < 5; k++) cycle();
        check("a_idle_rdy_cnt", 64'(cnt_a), 64'd1);
        rdy[0] = 1'b0;

        // Accept to c while draining a
        in_data = 32'h0A0A_0A0A; sel = 2'd0; in_valid = 1'b1;
        cycle();
        in_data = 32'h5555_5555; sel = 2'd2; rdy[0] = 1'b1;
        cycle();
        in_valid = 1'b0; rdy[0] = 1'b0;
        #1;
        check("indep_a_vld", 64'(vld_a), 64'h0);
        check("indep_a_cnt", 64'(cnt_a), 64'd2);
        check("indep_c_out", 64'(out_c), 64'h5555_5555);
        check("indep_c_vld", 64'(vld_c), 64'h1);

        // Fill all lanes, then reset asynchronously between edges
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k); in_data = 32'hF000_0000 + 32'(k);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("all_full", 64'({vld_a, vld_b, vld_c, vld_d}), 64'hF);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_vld", 64'({vld_a, vld_b, vld_c, vld_d}), 64'h0);
        check("async_out", 64'(out_a | out_b | out_c | out_d), 64'h0);
        check("async_cnt", 64'({cnt_a, cnt_b, cnt_c, cnt_d}), 64'h0);
        cycle();
        reset_n = 1'b1;
        in_data = 32'h7777_7777; sel = 2'd1; in_valid = 1'b1;
        #1;
        check("post_reset_ready", 64'(in_ready), 64'h1);
        cycle();
        in_valid = 1'b0;
        #1;
        check("post_reset_b", 64'(out_b), 64'h7777_7777);
        check("post_reset_vld", 64'(vld_b), 64'h1);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1x4_reg.md
# demux_1x4_reg

Registered 1-to-4 demultiplexer for the ALU datapath: it does the reverse of the 4:1 result mux. A single producer stream (`in_data`) is steered by a 2-bit select to one of four destination lanes (a, b, c, d). Each lane holds one word in its own holding register under a valid/ready handshake. The block sits between the ALU result bus and up to four consumers (register-file write port, HI/LO, branch unit, debug tap) and keeps a per-lane transfer count.

## Interface
- `WIDTH`, default 32: data width of input and every lane.
- `CNT_W`, default 8: width of each per-lane transfer counter.

- `clk`  input  1  single clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  WIDTH  word to route.
- `s1`, `s0`  input  1 each  lane select: 00 = a, 01 = b, 10 = c, 11 = d (same encoding as the 4:1 mux).
- `in_valid`  input  1  producer offers `in_data` with `s1`/`s0`.
- `in_ready`  output  1  block accepts this cycle.
- `out_a`, `out_b`, `out_c`, `out_d`  output  WIDTH each  lane holding registers.
- `vld_a` … `vld_d`  output  1 each  lane holds an undelivered word.
- `rdy_a` … `rdy_d`  input  1 each  consumer takes the lane word this cycle.
- `cnt_a` … `cnt_d`  output  CNT_W each  number of completed output transfers per lane, modulo 2^CNT_W.

## Operation
- Per lane x: holding register `out_x`, flag `vld_x`, counter `cnt_x`.
- Accept: `acc = in_valid & in_ready`. Selected lane L = {s1,s0}.
- `in_ready = !vld_L | rdy_L`. This is combinational from the select, the lane flag and the lane ready. It never depends on `in_valid`.
- Output transfer on lane x: `vld_x & rdy_x`. On this edge, `cnt_x` increments by 1 and wraps from 2^CNT_W−1 to 0.
- Per-lane next state, evaluated independently for all four lanes each cycle:
  - Accept into x, no drain of x: `out_x <= in_data`, `vld_x <= 1`.
  - Accept into x and drain of x in the same cycle: `out_x <= in_data`, `vld_x` stays 1. Full throughput, one word per cycle per lane.
  - Drain only: `vld_x <= 0`. `out_x` keeps its last value; it is not cleared.
  - Neither: hold.
- Unselected lanes are never written. A drain on lane b while lane a accepts is independent and legal.
- `in_valid` with L full and `rdy_L = 0`: `in_ready = 0`, nothing is written, and the producer must hold data and select stable.
- `rdy_x` while `vld_x = 0`: ignored, and the counter does not change.
- A lane word is delivered exactly once and never overwritten before its transfer.

## Timing
- Reset (async assert, any time, including mid-transfer): all `vld_*` = 0, all `out_*` = 0, all `cnt_*` = 0 immediately. Words in flight are discarded.
- Deassertion is used synchronously; the first accept can occur on the first rising edge after release.
- Latency: a word accepted at edge N appears on `out_L` with `vld_L = 1` after edge N and can be consumed in cycle N+1. Input-to-output latency is 1 cycle.
- `in_ready` settles within the same cycle as a change to `rdy_L`, `s1`/`s0` or `vld_L`. There is no registered backpressure.
- The counter value is visible the cycle after the transfer edge.
- Throughput: 1 word/cycle total when the selected lane's consumer keeps its ready asserted.

## Test plan
- Reset, then `in_data`=0x0000_00A5, select 10, `in_valid`=1 for one cycle, all ready 0 -> next cycle `vld_c`=1 and `out_c`=0x0000_00A5. Other valids stay 0. `in_ready` drops to 0 while select is still 10.
- Lane b full (0x1111_1111) and `rdy_b`=1, with simultaneous accept of 0x2222_2222 to b -> `vld_b` stays 1, `out_b`=0x2222_2222, `cnt_b`=1. No bubble over 10 back-to-back words; `cnt_b`=10 at the end.
- Lane a full with `rdy_a`=0, producer presents 0x3333_3333 to a -> `in_ready`=0 and `out_a` unchanged. Switch the select to d -> `in_ready`=1, and the word lands on d.
- Lane d drained 256 times with `CNT_W`=8 -> `cnt_d` passes 255 and then reads 0. Other counters stay 0.
- Assert `reset_n`=0 asynchronously, between edges, while all four lanes are valid -> all valids, data and counters read 0 before the next edge. After release, the first accept succeeds.
- `rdy_a`=1 with `vld_a`=0 for 5 cycles -> `cnt_a` stays 0. Accept to c and drain of a in the same cycle -> both take effect independently.
